mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit shift-add multiplier (`mul`) among several requesters. It accepts operand pairs over a req/gnt handshake and pulses `mul_ld` to start the datapath. It waits a fixed number of cycles, then captures `mul_ry` and returns the product tagged with the requester index. It sits between the requesting units and a single `mul` instance and is the only block that drives that instance's `ld`, `a` and `b`.

---
 rtl/mul_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mul_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
//   Round-robin arbiter/sequencer sharing a single shift-add multiplier among
//   NREQ requesters. It takes one operand pair over a req/gnt handshake,
//   loads the multiplier with a one-cycle mul_ld strobe, waits MUL_CYCLES
//   cycles and returns the captured product tagged with the requester index.
//
// Optional feature (compile-time macro): MUL_ARB_ZERO_BYPASS_EN
//   When defined, a grant whose A or B operand is zero skips the multiplier
//   (IDLE -> CAPT, no mul_ld) and returns result 0 with a 2-cycle latency.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   NREQ   per-requester request level, held until gnt
//   a_in/b_in  in   NREQ*WIDTH operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        out  NREQ   one-hot, one-cycle pulse when operands are taken
//   busy       out  1      high whenever the sequencer is not IDLE
//   done       out  1      one-cycle pulse, result/done_id valid
//   done_id    out  IDW    index of the requester owning result
//   result     out  2*WIDTH registered product, held until the next done
//   mul_ld     out  1      load strobe to the multiplier
//   mul_a/b    out  WIDTH  registered multiplier operands
//   mul_ry     in   2*WIDTH product from the multiplier
// ---------------------------------------------------------------------------
module mul_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 4,
  parameter int MUL_CYCLES = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [2*WIDTH-1:0]      result,
  output logic                    mul_ld,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_ry
);

  localparam int CNTW = $clog2(MUL_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [NREQ-1:0]      r_gnt;
  logic                 r_mul_ld;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic [IDW-1:0]       r_id;
  logic [IDW-1:0]       r_ptr;
  logic [CNTW-1:0]      r_cnt;
  logic                 r_done;
  logic [IDW-1:0]       r_done_id;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_found;
  logic                 w_grant;
  logic [IDW-1:0]       w_idx;
  logic [IDW-1:0]       w_win;
  logic [IDW-1:0]       w_ptr_nxt;
  logic [NREQ-1:0]      w_gnt_oh;
  logic [WIDTH-1:0]     w_a_sel;
  logic [WIDTH-1:0]     w_b_sel;

`ifdef MUL_ARB_ZERO_BYPASS_EN
  logic                 r_zero;
  logic                 w_zero;
`endif

  // Round-robin search: first requester at or above r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Winner's operands and one-hot grant vector.
  always_comb begin
    w_a_sel  = '0;
    w_b_sel  = '0;
    w_gnt_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_a_sel     = a_in[i*WIDTH +: WIDTH];
        w_b_sel     = b_in[i*WIDTH +: WIDTH];
        w_gnt_oh[i] = 1'b1;
      end
    end
  end

  // Explicit wrap so non-power-of-two NREQ stays in range.
  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

`ifdef MUL_ARB_ZERO_BYPASS_EN
  assign w_zero = (w_a_sel == '0) || (w_b_sel == '0);
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
`ifdef MUL_ARB_ZERO_BYPASS_EN
          w_state_nxt = w_zero ? S_CAPT : S_LOAD;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_CAPT;
        end
      end
      S_CAPT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, operand latch, cycle counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt     <= '0;
      r_mul_ld  <= 1'b0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_result  <= '0;
`ifdef MUL_ARB_ZERO_BYPASS_EN
      r_zero    <= 1'b0;
`endif
    end else begin
      r_gnt    <= w_grant ? w_gnt_oh : '0;
      // mul_ld is high exactly for the LOAD cycle.
      r_mul_ld <= (w_state_nxt == S_LOAD);
      r_done   <= 1'b0;
      if (w_grant) begin
        r_mul_a <= w_a_sel;
        r_mul_b <= w_b_sel;
        r_id    <= w_win;
        r_ptr   <= w_ptr_nxt;
`ifdef MUL_ARB_ZERO_BYPASS_EN
        r_zero  <= w_zero;
`endif
      end
      case (r_state)
        S_LOAD: r_cnt <= '0;
        S_RUN:  r_cnt <= r_cnt + 1'b1;
        S_CAPT: begin
`ifdef MUL_ARB_ZERO_BYPASS_EN
          r_result <= r_zero ? '0 : mul_ry;
`else
          r_result <= mul_ry;
`endif
          r_done_id <= r_id;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign result  = r_result;
  assign mul_ld  = r_mul_ld;
  assign mul_a   = r_mul_a;
  assign mul_b   = r_mul_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
//   Self-checking bench for mul_arbiter. A behavioural multiplier answers
//   mul_ld MUL_CYCLES edges later; a scoreboard holds the expected
//   {id, product, grant cycle} per grant and is checked when done pulses.
//   Expected grant order for each scenario is given as a list.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int MC   = 4;
  localparam int IDW  = 2;
  localparam int PW   = 2 * W;
  localparam int LAT  = MC + 2;  // gnt-visible cycle to done-visible cycle

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req;
  logic [NREQ*W-1:0]    a_in;
  logic [NREQ*W-1:0]    b_in;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic [PW-1:0]        result;
  logic                 mul_ld;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic [PW-1:0]        mul_ry = '0;

  always #5 clk = ~clk;

  mul_arbiter #(
    .NREQ       (NREQ),
    .WIDTH      (W),
    .MUL_CYCLES (MC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .mul_ld  (mul_ld),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ry  (mul_ry)
  );

  // Multiplier model: product appears MC edges after the edge sampling ld.
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           m_cnt = 0;
  bit           m_run = 1'b0;

  always @(posedge clk) begin
    if (mul_ld) begin
      m_a    <= mul_a;
      m_b    <= mul_b;
      m_cnt  <= 0;
      m_run  <= 1'b1;
      mul_ry <= '0;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == MC) begin
        mul_ry <= PW'(m_a) * PW'(m_b);
        m_run  <= 1'b0;
      end
    end
  end

  typedef struct {
    int id;
    int res;
    int cyc;
    bit byp;
    int a;
    int b;
  } exp_t;

  exp_t sb[$];
  int   order[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  int   n_done = 0;
  int   budget[NREQ];
  int   kgr[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int op_a(input int i, input int k);
    return (i * 5 + k * 7 + 3) % 16;
  endfunction

  function automatic int op_b(input int i, input int k);
    return (i * 3 + k * 11 + 1) % 16;
  endfunction

  function automatic bit is_byp(input int a, input int b);
`ifdef MUL_ARB_ZERO_BYPASS_EN
    return (a == 0) || (b == 0);
`else
    return (a < 0) && (b < 0);
`endif
  endfunction

  task automatic set_req(input int i, input int a, input int b, input int nb);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
    budget[i] = nb;
    kgr[i]    = 0;
    req[i]    = 1'b1;
  endtask

  // Per-cycle monitor: scoreboard pop on done, push on gnt, requester update.
  task automatic mon();
    exp_t e;
    int   w;
    int   a;
    int   b;
    cyc++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(done), 0);
      end else begin
        e = sb.pop_front();
        n_done++;
        chk("done_id", 32'(done_id), e.id);
        chk("result", 32'(result), e.res);
        chk("latency", cyc - e.cyc, e.byp ? 1 : LAT);
        if (!e.byp) begin
          chk("mul_a_hold", 32'(mul_a), e.a);
          chk("mul_b_hold", 32'(mul_b), e.b);
        end
      end
    end
    if (gnt != '0) begin
      if (order.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt), 0);
      end else begin
        w = order.pop_front();
        a = int'(a_in[w*W +: W]);
        b = int'(b_in[w*W +: W]);
        chk("gnt", 32'(gnt), 32'(1) << w);
        e.id  = w;
        e.byp = is_byp(a, b);
        e.res = e.byp ? 0 : a * b;
        e.cyc = cyc;
        e.a   = a;
        e.b   = b;
        sb.push_back(e);
        chk("mul_ld", 32'(mul_ld), e.byp ? 0 : 1);
        if (!e.byp) begin
          chk("mul_a", 32'(mul_a), a);
          chk("mul_b", 32'(mul_b), b);
        end
        kgr[w]++;
        budget[w]--;
        if (budget[w] <= 0) begin
          req[w] = 1'b0;
        end else begin
          a_in[w*W +: W] = W'(op_a(w, kgr[w]));
          b_in[w*W +: W] = W'(op_b(w, kgr[w]));
        end
      end
    end else if (mul_ld) begin
      chk("mul_ld_stray", 32'(mul_ld), 0);
    end
    chk("busy", 32'(busy), (sb.size() != 0) ? 1 : 0);
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input int target, input int lim);
    int t = 0;
    while (n_done < target && t < lim) begin
      step();
      t++;
    end
    chk("done_count", n_done, target);
    idle(3);
    chk("grants_left", order.size(), 0);
  endtask

  // Raise reset between clock edges; outputs must clear without an edge.
  task automatic rst_on();
    rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_mul_ld", 32'(mul_ld), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    sb.delete();
    order.delete();
    n_done = 0;
  endtask

  task automatic rst_off();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t;
    req  = '0;
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      budget[i] = 0;
      kgr[i]    = 0;
    end

    // Reset state
    @(negedge clk);
    rst_on();
    rst_off();

    // Single request: 3*13 = 39 from requester 0
    set_req(0, 3, 13, 1);
    order = '{0};
    run_until(1, 40);

    // Fairness: all four requesting from reset
    @(negedge clk);
    rst_on();
    for (int i = 0; i < NREQ; i++) set_req(i, op_a(i, 0), op_b(i, 0), (i == 0) ? 2 : 1);
    rst_off();
    order = '{0, 1, 2, 3, 0};
    n_done = 0;
    run_until(5, 100);

    // Hog: requesters 1 and 2 held, must alternate
    n_done = 0;
    set_req(1, op_a(1, 0), op_b(1, 0), 3);
    set_req(2, op_a(2, 0), op_b(2, 0), 3);
    order = '{1, 2, 1, 2, 1, 2};
    run_until(6, 120);

    // Maximum operands: ptr now 3, so requester 3 then 0
    n_done = 0;
    set_req(3, 15, 15, 1);
    set_req(0, 1, 15, 1);
    order = '{3, 0};
    run_until(2, 60);

    // Zero operand
    n_done = 0;
    set_req(1, 0, 9, 1);
    order = '{1};
    run_until(1, 40);

    // Reset in the second RUN cycle discards the operation
    n_done = 0;
    set_req(0, 5, 6, 1);
    order = '{0};
    t = 0;
    while (sb.size() == 0 && t < 20) begin
      step();
      t++;
    end
    chk("midrun_gnt_seen", sb.size(), 1);
    step();
    step();
    #2;
    rst_on();
    rst_off();
    idle(12);
    chk("midrun_no_done", n_done, 0);

    // After reset ptr is 0: requester 2 first, then 3
    set_req(2, 7, 9, 1);
    set_req(3, 11, 4, 1);
    order = '{2, 3};
    run_until(2, 60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
